// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared types and constants for the multicycle MIPS controller.
// Revision 1.0
`default_nettype none

package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_TRAP    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mips_mc_controller_aludec.sv
// mc_aludec: R-type funct to ALU operation decode with a funct-legal flag.
// Revision 1.0
`default_nettype none

module mc_aludec
  import mips_mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       funct_legal
);

  always_comb begin
    alu_op      = ALU_ADD;
    funct_legal = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: funct_legal = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_mc_controller.sv
// mips_mc_controller: multicycle MIPS control FSM (lw/sw/R-type/beq/bne/addi/j).
// Revision 1.0
`default_nettype none

module mips_mc_controller
  import mips_mc_pkg::*;
#(
  parameter int ALUCTRL_W     = 3,
  parameter int MEM_HANDSHAKE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic                 pcen,
  output logic [ALUCTRL_W-1:0] alucontrol,
  output logic                 illegal,
  output logic [3:0]           state
);

  state_t     state_r;
  state_t     next_state;
  logic [2:0] alu3;
  logic [2:0] rtype_alu;
  logic       funct_legal;
  logic       mem_done;

  mc_aludec u_aludec (
    .funct       (funct),
    .alu_op      (rtype_alu),
    .funct_legal (funct_legal)
  );

  assign mem_done = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
  assign state    = state_r;

  generate
    if (ALUCTRL_W > 3) begin : g_alu_wide
      assign alucontrol = {{(ALUCTRL_W-3){1'b0}}, alu3};
    end else begin : g_alu_narrow
      assign alucontrol = alu3;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= S_FETCH;
    else        state_r <= next_state;
  end

  always_comb begin
    next_state = state_r;
    mem_req    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REG;
    pcsrc      = PC_ALU;
    pcen       = 1'b0;
    alu3       = ALU_AND;
    illegal    = 1'b0;
    // Outputs stay quiet for as long as reset is held low.
    if (reset) begin
      case (state_r)
        S_FETCH: begin
          mem_req = 1'b1;
          alusrcb = SRCB_FOUR;
          alu3    = ALU_ADD;
          if (mem_done) begin
            irwrite    = 1'b1;
            pcen       = 1'b1;
            next_state = S_DECODE;
          end
        end
        S_DECODE: begin
          alusrcb = SRCB_IMMSH;
          alu3    = ALU_ADD;
          case (op)
            OP_LW, OP_SW:   next_state = S_MEMADR;
            OP_RTYPE:       next_state = funct_legal ? S_EXECUTE : S_TRAP;
            OP_BEQ, OP_BNE: next_state = S_BRANCH;
            OP_ADDI:        next_state = S_ADDIEX;
            OP_J:           next_state = S_JUMP;
            default:        next_state = S_TRAP;
          endcase
        end
        S_MEMADR: begin
          alusrca    = 1'b1;
          alusrcb    = SRCB_IMM;
          alu3       = ALU_ADD;
          next_state = (op == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_done) next_state = S_MEMWB;
        end
        S_MEMWB: begin
          memtoreg   = 1'b1;
          regwrite   = 1'b1;
          next_state = S_FETCH;
        end
        S_MEMWR: begin
          mem_req  = 1'b1;
          iord     = 1'b1;
          memwrite = 1'b1;
          if (mem_done) next_state = S_FETCH;
        end
        S_EXECUTE: begin
          alusrca    = 1'b1;
          alu3       = rtype_alu;
          next_state = funct_legal ? S_ALUWB : S_TRAP;
        end
        S_ALUWB: begin
          regdst     = 1'b1;
          regwrite   = 1'b1;
          next_state = S_FETCH;
        end
        S_BRANCH: begin
          alusrca    = 1'b1;
          alu3       = ALU_SUB;
          pcsrc      = PC_ALUOUT;
          pcen       = (op == OP_BEQ) ? zero : ~zero;
          next_state = S_FETCH;
        end
        S_ADDIEX: begin
          alusrca    = 1'b1;
          alusrcb    = SRCB_IMM;
          alu3       = ALU_ADD;
          next_state = S_ADDIWB;
        end
        S_ADDIWB: begin
          regwrite   = 1'b1;
          next_state = S_FETCH;
        end
        S_JUMP: begin
          pcsrc      = PC_JUMP;
          pcen       = 1'b1;
          next_state = S_FETCH;
        end
        default: begin
          // TRAP and the unused encodings lock up until reset.
          illegal    = 1'b1;
          next_state = S_TRAP;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
